// File: rtl/horner_poly_pipe_pkg.sv
// Shared defaults for the Horner odd-polynomial pipeline: fixed-point format,
// reset coefficient set and the configuration address map.
package horner_poly_pipe_pkg;

    localparam int FRAC_DEF      = 16;
    localparam int ACC_WIDTH_DEF = 32;

    localparam logic signed [31:0] K2_DEF = 32'sd8385;
    localparam logic signed [31:0] K1_DEF = -32'sd80774;
    localparam logic signed [31:0] K0_DEF = 32'sd350157;
    localparam logic signed [31:0] C0_DEF = -32'sd317475;

    // Packed {C0, K0, K1, K2}: C0 in the top slot, K[M-1] in the bottom slot
    localparam logic [127:0] COEF_INIT_DEF = {C0_DEF, K0_DEF, K1_DEF, K2_DEF};

    localparam int CFG_ADDR_C0     = 0;
    localparam int CFG_ADDR_K_BASE = 1;

endpackage

// File: rtl/horner_poly_pipe_mul_qf.sv
// Fixed-point multiply: full signed product, arithmetic shift right by FRAC
// (floor), truncated to Y_W bits.
module mul_qf
    import horner_poly_pipe_pkg::*;
#(
    parameter int A_W  = 32,
    parameter int B_W  = 32,
    parameter int Y_W  = 32,
    parameter int FRAC = FRAC_DEF
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [Y_W-1:0] y
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0] a_ext_s;
    logic signed [P_W-1:0] b_ext_s;
    logic signed [P_W-1:0] prod_s;

    // Sign-extend, multiply, floor-shift and truncate
    always_comb begin
        a_ext_s = P_W'($signed(a));
        b_ext_s = P_W'($signed(b));
        prod_s  = a_ext_s * b_ext_s;
        y       = Y_W'(prod_s >>> FRAC);
    end

endmodule

// File: rtl/horner_poly_pipe.sv
// Pipelined odd-polynomial evaluator y = r*(K[M-1]*r^2(M-1) + ... + K[0]) + C0
// with valid/ready flow control, drain-then-write coefficients, clamp and saturation.
module horner_poly_pipe
    import horner_poly_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int FRAC       = FRAC_DEF,
    parameter int M          = 3,
    parameter logic [(M+1)*ACC_WIDTH-1:0] COEF_INIT = COEF_INIT_DEF,
    parameter int CLAMP_EN   = 1,
    parameter int A_Q16      = 111411,
    parameter int SAT_EN     = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     r_q16,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_WIDTH-1:0]      ans_q16,
    input  logic                      cfg_we,
    output logic                      cfg_ready,
    input  logic [$clog2(M+1)-1:0]    cfg_addr,
    input  logic [ACC_WIDTH-1:0]      cfg_wdata
);

    localparam int AW = $clog2(M + 1);
    localparam int RW = DATA_WIDTH + 1;
    localparam logic [DATA_WIDTH-1:0] A_THR = DATA_WIDTH'(A_Q16);
    localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // vld_q[0] is stage 1, vld_q[M] is the output register
    logic [M:0]              vld_q, vld_d;
    logic [M-1:0]            gt_q, gt_d;
    logic [DATA_WIDTH-1:0]   r_q  [M];
    logic [DATA_WIDTH-1:0]   r_d  [M];
    logic [ACC_WIDTH-1:0]    r2_q [M-1];
    logic [ACC_WIDTH-1:0]    r2_d [M-1];
    logic [ACC_WIDTH-1:0]    s_q  [1:M-1];
    logic [ACC_WIDTH-1:0]    s_d  [1:M-1];
    logic [ACC_WIDTH-1:0]    coef_q [M+1];
    logic [ACC_WIDTH-1:0]    coef_d [M+1];
    logic [ACC_WIDTH-1:0]    ans_q, ans_d;

    logic [ACC_WIDTH-1:0]    r2_s;
    logic [ACC_WIDTH-1:0]    fin_s;
    logic [ACC_WIDTH-1:0]    sum_s [1:M-1];
    logic [ACC_WIDTH:0]      fin_sum_s;
    logic                    en_s, accept_s, cfg_hit_s;

    mul_qf #(.A_W(RW), .B_W(RW), .Y_W(ACC_WIDTH), .FRAC(FRAC)) u_mul_sq (
        .a ({1'b0, r_q16}),
        .b ({1'b0, r_q16}),
        .y (r2_s)
    );

    // Stage i+1 computes mul(a, r2) + K[M-1-i]; the first stage seeds a with K[M-1]
    for (genvar i = 1; i < M; i++) begin : g_stage
        logic [ACC_WIDTH-1:0] a_s;
        logic [ACC_WIDTH-1:0] p_s;
        if (i == 1) begin : g_first
            assign a_s = coef_q[CFG_ADDR_K_BASE + M - 1];
        end else begin : g_rest
            assign a_s = s_q[i-1];
        end
        mul_qf #(.A_W(ACC_WIDTH), .B_W(ACC_WIDTH), .Y_W(ACC_WIDTH), .FRAC(FRAC)) u_mul (
            .a (a_s),
            .b (r2_q[i-1]),
            .y (p_s)
        );
        assign sum_s[i] = p_s + coef_q[CFG_ADDR_K_BASE + M - 1 - i];
    end

    mul_qf #(.A_W(ACC_WIDTH), .B_W(RW), .Y_W(ACC_WIDTH), .FRAC(FRAC)) u_mul_out (
        .a (s_q[M-1]),
        .b ({1'b0, r_q[M-1]}),
        .y (fin_s)
    );

    // Handshake: every stage moves together on en; coefficient writes wait for an empty pipe
    always_comb begin
        en_s      = ~vld_q[M] | out_ready;
        in_ready  = en_s & ~cfg_we;
        cfg_ready = ~(|vld_q);
        accept_s  = in_valid & in_ready;
        cfg_hit_s = cfg_we & cfg_ready & ({1'b0, cfg_addr} <= (AW+1)'(M));
    end

    // Datapath next state, final add with clamp / saturation
    always_comb begin
        vld_d     = vld_q;
        gt_d      = gt_q;
        r_d       = r_q;
        r2_d      = r2_q;
        s_d       = s_q;
        ans_d     = ans_q;
        fin_sum_s = {fin_s[ACC_WIDTH-1], fin_s}
                  + {coef_q[CFG_ADDR_C0][ACC_WIDTH-1], coef_q[CFG_ADDR_C0]};
        if (en_s) begin
            vld_d   = {vld_q[M-1:0], accept_s};
            gt_d    = {gt_q[M-2:0], (r_q16 > A_THR)};
            r_d[0]  = r_q16;
            r2_d[0] = r2_s;
            for (int i = 1; i < M; i++) begin
                r_d[i] = r_q[i-1];
                s_d[i] = sum_s[i];
            end
            for (int i = 1; i < M - 1; i++) begin
                r2_d[i] = r2_q[i-1];
            end
            if ((CLAMP_EN != 0) && gt_q[M-1]) begin
                ans_d = {ACC_WIDTH{1'b0}};
            end else if ((SAT_EN != 0) && (fin_sum_s[ACC_WIDTH] != fin_sum_s[ACC_WIDTH-1])) begin
                ans_d = fin_sum_s[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
            end else begin
                ans_d = fin_sum_s[ACC_WIDTH-1:0];
            end
        end else begin
            ans_d = ans_q;
        end
    end

    // Coefficient bank write; out-of-range addresses complete but are dropped
    always_comb begin
        coef_d = coef_q;
        if (cfg_hit_s) begin
            coef_d[cfg_addr] = cfg_wdata;
        end else begin
            coef_d = coef_q;
        end
    end

    // State registers; the coefficient bank reloads its power-on set on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= {(M+1){1'b0}};
            gt_q  <= {M{1'b0}};
            ans_q <= {ACC_WIDTH{1'b0}};
            for (int i = 0; i < M; i++)     r_q[i]  <= {DATA_WIDTH{1'b0}};
            for (int i = 0; i < M - 1; i++) r2_q[i] <= {ACC_WIDTH{1'b0}};
            for (int i = 1; i < M; i++)     s_q[i]  <= {ACC_WIDTH{1'b0}};
            for (int k = 0; k <= M; k++)    coef_q[k] <= COEF_INIT[(M-k)*ACC_WIDTH +: ACC_WIDTH];
        end else begin
            vld_q  <= vld_d;
            gt_q   <= gt_d;
            ans_q  <= ans_d;
            r_q    <= r_d;
            r2_q   <= r2_d;
            s_q    <= s_d;
            coef_q <= coef_d;
        end
    end

    assign out_valid = vld_q[M];
    assign ans_q16   = ans_q;

endmodule
